// File: rtl/obstacle_pkg.sv
// ---------------------------------------------------------------------------
// obstacle_pkg
// Shared definitions for the multi-channel obstacle detector:
//   level_t       - per-channel warning level, encoded as the buzz_level code
//   DEF_*         - default parameter values used by the top and the channel
//   drive_bit()   - buzzer waveform selection for one channel
// ---------------------------------------------------------------------------
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN1 = 2'd1,
    WARN2 = 2'd2,
    ALARM = 2'd3
  } level_t;

  localparam int unsigned DEF_N_CH         = 32'd4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 32'd16;
  localparam int unsigned DEF_ESC_CYC      = 32'd1024;
  localparam int unsigned DEF_PULSE_SLOW   = 32'd256;
  localparam int unsigned DEF_PULSE_FAST   = 32'd64;

  // Buzzer waveform for a level: silent, slow square, fast square, steady on.
  function automatic logic drive_bit(input level_t lvl, input logic slow_bit,
                                     input logic fast_bit);
    logic d;
    case (lvl)
      IDLE:    d = 1'b0;
      WARN1:   d = slow_bit;
      WARN2:   d = fast_bit;
      ALARM:   d = 1'b1;
      default: d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/obstacle_channel.sv
// ---------------------------------------------------------------------------
// obstacle_channel
// One sensor channel: 2-flop synchroniser, debounce filter, escalation
// counter and warning-level FSM.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   active_i     - channel enabled (mask & global enable); low forces IDLE
//                  and clears debounce/escalation state
//   sensor_i     - raw asynchronous obstacle input
//   level_o      - registered warning level
//   level_d_o    - next-state level (lets the top register its outputs in
//                  step with level_o)
//   deb_o        - registered debounced sensor value
// ---------------------------------------------------------------------------
module obstacle_channel
  import obstacle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned ESC_CYC      = DEF_ESC_CYC
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   active_i,
  input  logic   sensor_i,
  output level_t level_o,
  output level_t level_d_o,
  output logic   deb_o
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 32'd1);
  localparam int unsigned EW = $clog2(ESC_CYC + 32'd1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 32'd1);
  localparam logic [EW-1:0] ESC_LAST = EW'(ESC_CYC - 32'd1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [EW-1:0] ecnt_q, ecnt_d;
  level_t        state_q, state_d;

  // Debounce: count consecutive samples that disagree with the held value.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = {DW{1'b0}};
    if (!active_i) begin
      deb_d  = 1'b0;
      dcnt_d = {DW{1'b0}};
    end else if (sync2_q == deb_q) begin
      dcnt_d = {DW{1'b0}};
    end else if (dcnt_q == DEB_LAST) begin
      deb_d  = ~deb_q;
      dcnt_d = {DW{1'b0}};
    end else begin
      dcnt_d = dcnt_q + DW'(1);
    end
  end

  // Level FSM: a debounced low (or an inactive channel) always wins.
  always_comb begin
    state_d = state_q;
    if (!active_i || !deb_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WARN1;
        WARN1:   state_d = (ecnt_q == ESC_LAST) ? WARN2 : WARN1;
        WARN2:   state_d = (ecnt_q == ESC_LAST) ? ALARM : WARN2;
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  // Escalation counter: zero on any level change and while idle, saturating.
  always_comb begin
    if ((state_d != state_q) || (state_d == IDLE)) begin
      ecnt_d = {EW{1'b0}};
    end else if (ecnt_q != ESC_LAST) begin
      ecnt_d = ecnt_q + EW'(1);
    end else begin
      ecnt_d = ecnt_q;
    end
  end

  // Synchroniser runs regardless of active_i so re-enable sees current input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= 1'b0;
      dcnt_q  <= {DW{1'b0}};
      ecnt_q  <= {EW{1'b0}};
      state_q <= IDLE;
    end else begin
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      ecnt_q  <= ecnt_d;
      state_q <= state_d;
    end
  end

  assign level_o   = state_q;
  assign level_d_o = state_d;
  assign deb_o     = deb_q;

endmodule

// File: rtl/obstacle_detect_multi.sv
// ---------------------------------------------------------------------------
// obstacle_detect_multi
// N_CH-channel obstacle warning controller with escalating buzzer output.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   en            - global enable, low forces every channel idle
//   sensor        - raw asynchronous obstacle inputs (1 = obstacle)
//   ch_mask       - per-channel enable (1 = active)
//   clr           - pulse clearing alarm_seen
//   buzz_level    - per-channel level code, channel i at [2i+1:2i]
//   buzz_drv      - per-channel buzzer waveform
//   any_obstacle  - any active channel has a debounced obstacle
//   alarm_seen    - sticky flag, set when a channel enters ALARM
// ---------------------------------------------------------------------------
module obstacle_detect_multi
  import obstacle_pkg::*;
#(
  parameter int unsigned N_CH         = DEF_N_CH,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned ESC_CYC      = DEF_ESC_CYC,
  parameter int unsigned PULSE_SLOW   = DEF_PULSE_SLOW,
  parameter int unsigned PULSE_FAST   = DEF_PULSE_FAST
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_CH-1:0]     sensor,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic                clr,
  output logic [2*N_CH-1:0]   buzz_level,
  output logic [N_CH-1:0]     buzz_drv,
  output logic                any_obstacle,
  output logic                alarm_seen
);

  localparam int unsigned PW = $clog2(PULSE_SLOW);
  // Fast-waveform tap; a PULSE_FAST of 1 has no meaningful bit, use bit 0.
  localparam int unsigned FB = (PULSE_FAST > 32'd1) ? ($clog2(PULSE_FAST) - 32'd1) : 32'd0;

  logic [N_CH-1:0] active_s;
  logic [N_CH-1:0] deb_s;
  level_t          lvl_q_s [N_CH];
  level_t          lvl_d_s [N_CH];

  logic [PW-1:0]   pulse_q, pulse_d;
  logic [N_CH-1:0] drv_q, drv_d;
  logic            any_q, any_d;
  logic            alarm_q, alarm_d;
  logic            enter_s;

  assign active_s = ch_mask & {N_CH{en}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    obstacle_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ESC_CYC      (ESC_CYC)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .active_i  (active_s[i]),
      .sensor_i  (sensor[i]),
      .level_o   (lvl_q_s[i]),
      .level_d_o (lvl_d_s[i]),
      .deb_o     (deb_s[i])
    );
    assign buzz_level[2*i+1:2*i] = lvl_q_s[i];
  end

  // Next values of the shared counter and registered outputs. The drive is
  // built from next-state level and counter so it lines up with buzz_level.
  always_comb begin
    pulse_d = pulse_q + PW'(1);
    drv_d   = {N_CH{1'b0}};
    enter_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      drv_d[i] = drive_bit(lvl_d_s[i], pulse_d[PW-1], pulse_d[FB]);
      if ((lvl_d_s[i] == ALARM) && (lvl_q_s[i] != ALARM)) begin
        enter_s = 1'b1;
      end
    end
    any_d = en & (|(deb_s & ch_mask));
    if (enter_s) begin
      alarm_d = 1'b1;
    end else if (clr) begin
      alarm_d = 1'b0;
    end else begin
      alarm_d = alarm_q;
    end
  end

  // Shared pulse counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= {PW{1'b0}};
      drv_q   <= {N_CH{1'b0}};
      any_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      drv_q   <= drv_d;
      any_q   <= any_d;
      alarm_q <= alarm_d;
    end
  end

  assign buzz_drv     = drv_q;
  assign any_obstacle = any_q;
  assign alarm_seen   = alarm_q;

endmodule

// File: tb/tb_obstacle_detect_multi.sv
// ---------------------------------------------------------------------------
// tb_obstacle_detect_multi
// Directed scenarios plus randomized stimulus against a time-based model:
// level = f(cycles the debounced obstacle has been seen), drive = f(level,
// cycle count since reset).
// ---------------------------------------------------------------------------
module tb_obstacle_detect_multi;

  localparam int N_CH  = 4;
  localparam int DEB   = 4;
  localparam int ESC   = 16;
  localparam int PSLOW = 8;
  localparam int PFAST = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [N_CH-1:0]  sensor;
  logic [N_CH-1:0]  ch_mask;
  logic             clr;
  logic [2*N_CH-1:0] buzz_level;
  logic [N_CH-1:0]  buzz_drv;
  logic             any_obstacle;
  logic             alarm_seen;

  obstacle_detect_multi #(
    .N_CH(N_CH), .DEBOUNCE_CYC(DEB), .ESC_CYC(ESC),
    .PULSE_SLOW(PSLOW), .PULSE_FAST(PFAST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sensor(sensor), .ch_mask(ch_mask),
    .clr(clr), .buzz_level(buzz_level), .buzz_drv(buzz_drv),
    .any_obstacle(any_obstacle), .alarm_seen(alarm_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit s1_m [N_CH];
  bit s2_m [N_CH];
  bit deb_m [N_CH];
  int run_m [N_CH];
  int on_m [N_CH];
  int lvl_m [N_CH];
  int pc_m;
  bit any_m;
  bit alarm_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      s1_m[c] = 0; s2_m[c] = 0; deb_m[c] = 0; run_m[c] = 0; on_m[c] = 0; lvl_m[c] = 0;
    end
    pc_m = 0; any_m = 0; alarm_m = 0;
  endtask

  // One rising edge of the model.
  task automatic model_edge();
    bit enter;
    bit [N_CH-1:0] old_deb;
    int old_lvl;
    int lv;
    enter = 0;
    for (int c = 0; c < N_CH; c++) begin
      bit act;
      act = en && ch_mask[c];
      old_deb[c] = deb_m[c];
      old_lvl = lvl_m[c];
      if (!act) begin
        deb_m[c] = 0; run_m[c] = 0;
      end else if (s2_m[c] == deb_m[c]) begin
        run_m[c] = 0;
      end else begin
        run_m[c]++;
        if (run_m[c] == DEB) begin deb_m[c] = ~deb_m[c]; run_m[c] = 0; end
      end
      if (act && old_deb[c]) on_m[c]++; else on_m[c] = 0;
      lv = (on_m[c] == 0) ? 0 : 1 + (on_m[c] - 1) / ESC;
      lvl_m[c] = (lv > 3) ? 3 : lv;
      if (lvl_m[c] == 3 && old_lvl != 3) enter = 1;
      s2_m[c] = s1_m[c];
      s1_m[c] = sensor[c];
    end
    any_m = en && ((old_deb & ch_mask) != '0);
    pc_m = (pc_m + 1) % PSLOW;
    if (enter) alarm_m = 1;
    else if (clr) alarm_m = 0;
  endtask

  task automatic check_all();
    logic [2*N_CH-1:0] el;
    logic [N_CH-1:0] ed;
    for (int c = 0; c < N_CH; c++) begin
      el[2*c +: 2] = 2'(lvl_m[c]);
      case (lvl_m[c])
        0: ed[c] = 1'b0;
        1: ed[c] = 1'((pc_m / (PSLOW / 2)) % 2);
        2: ed[c] = 1'((pc_m / (PFAST / 2)) % 2);
        default: ed[c] = 1'b1;
      endcase
    end
    chk("buzz_level", 32'(buzz_level), 32'(el));
    chk("buzz_drv", 32'(buzz_drv), 32'(ed));
    chk("any_obstacle", 32'(any_obstacle), 32'(any_m));
    chk("alarm_seen", 32'(alarm_seen), 32'(alarm_m));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic d2 [40];
    int bad;
    int ones;
    int idx;

    rst_n = 1'b1; en = 1'b0; sensor = '0; ch_mask = '0; clr = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_level", 32'(buzz_level), 32'd0);
    chk("reset_drv", 32'(buzz_drv), 32'd0);
    chk("reset_any", 32'(any_obstacle), 32'd0);
    chk("reset_alarm", 32'(alarm_seen), 32'd0);
    ticks(2);
    rst_n = 1'b1; en = 1'b1; ch_mask = 4'hF;
    ticks(4);

    // 3-cycle glitch on channel 1 is filtered
    sensor[1] = 1'b1;
    ticks(3);
    sensor[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_level1", 32'(buzz_level[3:2]), 32'd0);
      chk("glitch_any", 32'(any_obstacle), 32'd0);
    end

    // channel 0 escalation timeline
    sensor[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 6)  chk("ch0_lvl_c6", 32'(buzz_level[1:0]), 32'd0);
      if (k == 7)  chk("ch0_lvl_c7", 32'(buzz_level[1:0]), 32'd1);
      if (k == 7)  chk("ch0_any_c7", 32'(any_obstacle), 32'd1);
      if (k == 22) chk("ch0_lvl_c22", 32'(buzz_level[1:0]), 32'd1);
      if (k == 23) chk("ch0_lvl_c23", 32'(buzz_level[1:0]), 32'd2);
      if (k == 38) chk("ch0_alarm_c38", 32'(alarm_seen), 32'd0);
      if (k == 39) chk("ch0_lvl_c39", 32'(buzz_level[1:0]), 32'd3);
      if (k == 39) chk("ch0_alarm_c39", 32'(alarm_seen), 32'd1);
    end

    // channel 2 drive waveform per level
    sensor[2] = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      tick();
      d2[k] = buzz_drv[2];
    end
    bad = 0; ones = 0;
    for (int k = 7; k <= 22; k++) ones += int'(d2[k]);
    for (int k = 11; k <= 22; k++) if (d2[k] == d2[k-4]) bad++;
    chk("warn1_drv_duty", 32'(ones), 32'd8);
    chk("warn1_drv_period", 32'(bad), 32'd0);
    bad = 0; ones = 0;
    for (int k = 23; k <= 38; k++) ones += int'(d2[k]);
    for (int k = 25; k <= 38; k++) if (d2[k] == d2[k-2]) bad++;
    chk("warn2_drv_duty", 32'(ones), 32'd8);
    chk("warn2_drv_period", 32'(bad), 32'd0);
    chk("alarm_drv", 32'(d2[39]), 32'd1);

    // channel 3 to ALARM, then masked
    sensor[3] = 1'b1;
    ticks(39);
    chk("ch3_alarm_lvl", 32'(buzz_level[7:6]), 32'd3);
    ch_mask[3] = 1'b0;
    tick();
    chk("mask_lvl3", 32'(buzz_level[7:6]), 32'd0);
    chk("mask_drv3", 32'(buzz_drv[3]), 32'd0);
    chk("mask_alarm_kept", 32'(alarm_seen), 32'd1);
    ticks(3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_alarm", 32'(alarm_seen), 32'd0);

    // re-enable with sensor already high restarts debounce
    ch_mask[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) chk("reen_lvl_c4", 32'(buzz_level[7:6]), 32'd0);
      if (k == 5) chk("reen_lvl_c5", 32'(buzz_level[7:6]), 32'd1);
    end

    // clr coinciding with channel 1 entering ALARM
    sensor[1] = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      clr = (k == 35 || k == 39);
      tick();
      if (k == 35) chk("clr_no_entry", 32'(alarm_seen), 32'd0);
      if (k == 39) chk("set_wins", 32'(alarm_seen), 32'd1);
    end
    clr = 1'b0;

    // async reset mid-WARN2
    sensor = '0;
    ticks(10);
    sensor[2] = 1'b1;
    ticks(30);
    chk("pre_rst_lvl2", 32'(buzz_level[5:4]), 32'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_level", 32'(buzz_level), 32'd0);
    chk("async_rst_drv", 32'(buzz_drv), 32'd0);
    chk("async_rst_any", 32'(any_obstacle), 32'd0);
    chk("async_rst_alarm", 32'(alarm_seen), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("post_rst_lvl_c6", 32'(buzz_level[5:4]), 32'd0);
      if (k == 7) chk("post_rst_lvl_c7", 32'(buzz_level[5:4]), 32'd1);
    end

    // randomized traffic: slow then fast sensor activity
    for (int k = 0; k < 900; k++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, (k < 500) ? 45 : 6) == 0) sensor[c] = ~sensor[c];
      if ($urandom_range(0, 90) == 0) begin
        idx = int'($urandom_range(0, N_CH - 1));
        ch_mask[idx] = ~ch_mask[idx];
      end
      if (en && $urandom_range(0, 200) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 12) == 0) en = 1'b1;
      clr = ($urandom_range(0, 30) == 0);
      tick();
    end

    // global disable forces everything idle
    en = 1'b0; clr = 1'b0;
    tick();
    chk("en_off_level", 32'(buzz_level), 32'd0);
    chk("en_off_drv", 32'(buzz_drv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
